// File: rtl/core_pkg.sv
// Shared definitions for the core input-byte stage: FSM states and register constants.
package core_pkg;

  typedef enum logic [1:0] {
    INP_IDLE  = 2'd0,
    INP_WAIT  = 2'd1,
    INP_WRITE = 2'd2
  } inp_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/core_byte_fifo.sv
// Byte FIFO with occupancy count; callers must gate push/pop with full/empty.
module core_byte_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr, rptr;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rptr];

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/core_inport.sv
// IN-instruction servicing: buffers UART bytes and writes one byte into the register file per request.
module core_inport
  import core_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          RX_VALID,
  input  logic [7:0]    RX_DATA,
  output logic          RX_READY,
  input  logic          REQ,
  input  logic [4:0]    REQ_RD,
  output logic          BUSY,
  output logic          DONE,
  output logic          INE,
  output logic [7:0]    INDATA,
  output logic [4:0]    IN_WADDR,
  output logic [AW:0]   COUNT,
  output logic          OVERFLOW
);

  inp_state_e state_q, state_d;
  logic [4:0] rd_q;
  logic [7:0] data_q, fifo_dout;
  logic       fifo_full, fifo_empty, push, pop;

  assign push = RX_VALID && !fifo_full;

  core_byte_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
    .clk   (CLK),
    .rst_n (RST_N),
    .push  (push),
    .pop   (pop),
    .din   (RX_DATA),
    .dout  (fifo_dout),
    .count (COUNT),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      INP_IDLE:  if (REQ) state_d = INP_WAIT;
      INP_WAIT:  if (!fifo_empty) begin
                   pop     = 1'b1;
                   state_d = INP_WRITE;
                 end
      INP_WRITE: state_d = INP_IDLE;
      default:   state_d = INP_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q  <= INP_IDLE;
      rd_q     <= '0;
      data_q   <= '0;
      OVERFLOW <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == INP_IDLE && REQ) rd_q <= REQ_RD;
      if (pop) data_q <= fifo_dout;
      // Full is judged before any same-cycle pop, so the byte is still lost.
      if (RX_VALID && fifo_full) OVERFLOW <= 1'b1;
    end
  end

  assign RX_READY = !fifo_full;
  assign BUSY     = (state_q != INP_IDLE);
  assign DONE     = (state_q == INP_WRITE);
  assign INE      = (state_q == INP_WRITE) && (rd_q != REG_ZERO);
  assign INDATA   = data_q;
  assign IN_WADDR = rd_q;

endmodule

// File: tb/tb_core_inport.sv
// Self-checking bench for core_inport: directed scenarios plus a randomized streaming test with a queue model.
module tb_core_inport;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        RX_VALID = 1'b0;
  logic [7:0]  RX_DATA = '0;
  logic        RX_READY;
  logic        REQ = 1'b0;
  logic [4:0]  REQ_RD = '0;
  logic        BUSY, DONE, INE, OVERFLOW;
  logic [7:0]  INDATA;
  logic [4:0]  IN_WADDR;
  logic [AW:0] COUNT;

  int n_cmp = 0;
  int n_fail = 0;

  core_inport #(.DEPTH(DEPTH), .AW(AW)) dut (
    .CLK(CLK), .RST_N(RST_N), .RX_VALID(RX_VALID), .RX_DATA(RX_DATA),
    .RX_READY(RX_READY), .REQ(REQ), .REQ_RD(REQ_RD), .BUSY(BUSY), .DONE(DONE),
    .INE(INE), .INDATA(INDATA), .IN_WADDR(IN_WADDR), .COUNT(COUNT), .OVERFLOW(OVERFLOW)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    RX_VALID = 1'b1;
    RX_DATA  = b;
    tick();
    RX_VALID = 1'b0;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    tick();
    tick();
    RST_N = 1'b1;
    n_cmp++;
    if ({COUNT, BUSY, DONE, INE, OVERFLOW, RX_READY} !== {5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_ctrl: count=%0d busy=%b done=%b ine=%b ovf=%b rdy=%b, want 0 0 0 0 0 1",
               COUNT, BUSY, DONE, INE, OVERFLOW, RX_READY);
    end
    n_cmp++;
    if ({INDATA, IN_WADDR} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_data: indata=%h waddr=%0d, want 00 0", INDATA, IN_WADDR);
    end
  endtask

  task automatic test_basic();
    push_byte(8'h41);
    n_cmp++;
    if (COUNT !== 5'd1) begin n_fail++; $display("FAIL basic_count1: got %0d want 1", COUNT); end
    tick(); tick();
    REQ = 1'b1; REQ_RD = 5'd5;
    tick();
    REQ = 1'b0;
    n_cmp++;
    if ({BUSY, INE, DONE, COUNT} !== {1'b1, 1'b0, 1'b0, 5'd1}) begin
      n_fail++;
      $display("FAIL basic_wait: busy=%b ine=%b done=%b count=%0d, want 1 0 0 1", BUSY, INE, DONE, COUNT);
    end
    tick();
    n_cmp++;
    if ({BUSY, INE, DONE, INDATA, IN_WADDR, COUNT} !== {1'b1, 1'b1, 1'b1, 8'h41, 5'd5, 5'd0}) begin
      n_fail++;
      $display("FAIL basic_write: busy=%b ine=%b done=%b data=%h waddr=%0d count=%0d, want 1 1 1 41 5 0",
               BUSY, INE, DONE, INDATA, IN_WADDR, COUNT);
    end
    tick();
    n_cmp++;
    if ({BUSY, INE, DONE, INDATA, IN_WADDR} !== {1'b0, 1'b0, 1'b0, 8'h41, 5'd5}) begin
      n_fail++;
      $display("FAIL basic_after: busy=%b ine=%b done=%b data=%h waddr=%0d, want 0 0 0 41 5",
               BUSY, INE, DONE, INDATA, IN_WADDR);
    end
  endtask

  task automatic test_stall();
    int bad = 0;
    REQ = 1'b1; REQ_RD = 5'd7;
    tick();
    REQ = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (BUSY !== 1'b1 || INE !== 1'b0 || DONE !== 1'b0) bad++;
      tick();
    end
    n_cmp++;
    if (bad != 0) begin n_fail++; $display("FAIL stall_hold: %0d bad cycles, want 0", bad); end
    push_byte(8'h5A);
    n_cmp++;
    if ({BUSY, INE, COUNT} !== {1'b1, 1'b0, 5'd1}) begin
      n_fail++;
      $display("FAIL stall_pushed: busy=%b ine=%b count=%0d, want 1 0 1", BUSY, INE, COUNT);
    end
    tick();
    n_cmp++;
    if ({INE, DONE, INDATA, IN_WADDR} !== {1'b1, 1'b1, 8'h5A, 5'd7}) begin
      n_fail++;
      $display("FAIL stall_write: ine=%b done=%b data=%h waddr=%0d, want 1 1 5a 7", INE, DONE, INDATA, IN_WADDR);
    end
    tick();
  endtask

  task automatic test_x0();
    push_byte(8'h33);
    REQ = 1'b1; REQ_RD = 5'd0;
    tick();
    REQ = 1'b0;
    tick();
    n_cmp++;
    if ({DONE, INE, COUNT, INDATA} !== {1'b1, 1'b0, 5'd0, 8'h33}) begin
      n_fail++;
      $display("FAIL x0_write: done=%b ine=%b count=%0d data=%h, want 1 0 0 33", DONE, INE, COUNT, INDATA);
    end
    tick();
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i < 17; i++) begin
      RX_VALID = 1'b1;
      RX_DATA  = 8'(i);
      tick();
      if (i == 14) begin
        n_cmp++;
        if (RX_READY !== 1'b1) begin n_fail++; $display("FAIL fill_ready15: got %b want 1", RX_READY); end
      end
      if (i == 15) begin
        n_cmp++;
        if ({RX_READY, COUNT, OVERFLOW} !== {1'b0, 5'd16, 1'b0}) begin
          n_fail++;
          $display("FAIL fill_full: rdy=%b count=%0d ovf=%b, want 0 16 0", RX_READY, COUNT, OVERFLOW);
        end
      end
    end
    RX_VALID = 1'b0;
    n_cmp++;
    if ({COUNT, OVERFLOW} !== {5'd16, 1'b1}) begin
      n_fail++;
      $display("FAIL fill_ovf: count=%0d ovf=%b, want 16 1", COUNT, OVERFLOW);
    end
    for (int i = 0; i < 16; i++) begin
      REQ = 1'b1; REQ_RD = 5'(i + 1);
      tick();
      REQ = 1'b0;
      tick();
      n_cmp++;
      if ({INE, INDATA, IN_WADDR} !== {1'b1, 8'(i), 5'(i + 1)}) begin
        n_fail++;
        $display("FAIL fill_drain%0d: ine=%b data=%h waddr=%0d, want 1 %h %0d", i, INE, INDATA, IN_WADDR, 8'(i), i + 1);
      end
      tick();
    end
    n_cmp++;
    if ({COUNT, OVERFLOW} !== {5'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL fill_empty: count=%0d ovf=%b, want 0 1", COUNT, OVERFLOW);
    end
  endtask

  task automatic test_wrap_stream();
    logic [7:0] exp_q[$];
    logic [4:0] rd_q[$];
    logic [7:0] exp_b;
    logic [4:0] exp_rd;
    int acc = 0, dlv = 0, sent = 0, cyc = 0;
    for (int i = 0; i < 40; i++) exp_q.push_back(8'($urandom));
    while (dlv < 40 && cyc < 2000) begin
      RX_VALID = (sent < 40) && ((acc - dlv) < DEPTH);
      RX_DATA  = (sent < 40) ? exp_q[sent] : 8'h00;
      REQ = 1'b0;
      if (!BUSY && ($urandom_range(0, 3) != 0)) begin
        REQ = 1'b1;
        REQ_RD = 5'($urandom_range(1, 31));
        rd_q.push_back(REQ_RD);
      end
      tick();
      cyc++;
      if (RX_VALID) begin sent++; acc++; end
      if (DONE) begin
        exp_b = exp_q[dlv];
        exp_rd = rd_q.pop_front();
        dlv++;
        n_cmp++;
        if ({INE, INDATA, IN_WADDR} !== {1'b1, exp_b, exp_rd}) begin
          n_fail++;
          $display("FAIL stream_byte%0d: ine=%b data=%h waddr=%0d, want 1 %h %0d", dlv - 1, INE, INDATA, IN_WADDR, exp_b, exp_rd);
        end
      end
      n_cmp++;
      if (COUNT !== 5'(acc - dlv) || COUNT > 5'(DEPTH)) begin
        n_fail++;
        $display("FAIL stream_count cyc%0d: got %0d want %0d", cyc, COUNT, acc - dlv);
      end
    end
    RX_VALID = 1'b0;
    REQ = 1'b0;
    n_cmp++;
    if (dlv != 40) begin n_fail++; $display("FAIL stream_timeout: delivered %0d want 40", dlv); end
    tick(); tick();
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    push_byte(8'hA1); push_byte(8'hA2); push_byte(8'hA3);
    REQ = 1'b1; REQ_RD = 5'd9;
    tick();
    REQ = 1'b0;
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
    n_cmp++;
    if ({COUNT, BUSY, INE, DONE, OVERFLOW} !== {5'd0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL rstmid_state: count=%0d busy=%b ine=%b done=%b ovf=%b, want 0 0 0 0 0",
               COUNT, BUSY, INE, DONE, OVERFLOW);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      if (INE !== 1'b0 || DONE !== 1'b0 || BUSY !== 1'b0 || COUNT !== 5'd0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin n_fail++; $display("FAIL rstmid_quiet: %0d bad cycles, want 0", bad); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_x0();
    test_fill_overflow();
    test_wrap_stream();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/core_inport.md
Name: core_inport

Overview:
- Input-byte stage directly upstream of the core register file.
- Buffers received bytes from the UART receiver in a small FIFO.
- Services the core's IN instruction: waits for a byte, then drives the register file's byte-write port (INE/INDATA plus destination address) for exactly one cycle.
- Stalls the pipeline via BUSY while no byte is available.

Parameters:
- DEPTH, 16, FIFO depth in bytes; power of two, 2..256.
- AW, 4, pointer width; must equal log2(DEPTH).

Ports:
- CLK  input  1  core clock.
- RST_N  input  1  synchronous active-low reset, sampled on rising CLK.
- RX_VALID  input  1  UART receiver presents a byte this cycle.
- RX_DATA  input  8  received byte.
- RX_READY  output  1  FIFO not full; equals !full.
- REQ  input  1  IN instruction issued (one-cycle pulse from execute).
- REQ_RD  input  5  destination register of the IN instruction.
- BUSY  output  1  stall request to the core.
- DONE  output  1  one-cycle pulse when the IN instruction retires.
- INE  output  1  byte-write enable to the register file.
- INDATA  output  8  byte written into bits [7:0] of the destination; bits [31:8] are preserved by the register file.
- IN_WADDR  output  5  destination register for the byte write.
- COUNT  output  AW+1  current FIFO occupancy, 0..DEPTH.
- OVERFLOW  output  1  sticky flag: a byte was dropped because the FIFO was full.

Behaviour:
- Reset (RST_N=0 at a CLK edge):
  - FIFO pointers and COUNT go to 0; state goes to IDLE.
  - BUSY, DONE, INE, OVERFLOW all 0; INDATA=0, IN_WADDR=0.
  - Reset mid-operation abandons any pending request and discards all buffered bytes.
- FIFO push: when RX_VALID=1 and not full, RX_DATA is written at the write pointer, which then increments with natural wrap modulo DEPTH.
- Overflow: when RX_VALID=1 and full, the byte is dropped and OVERFLOW is set. This holds even if a pop happens in the same cycle. OVERFLOW clears only on reset.
- FIFO pop: occurs only in state WAIT when not empty. The read pointer increments with wrap.
- Simultaneous push and pop: both take effect; COUNT is unchanged.
- No bypass path: a byte pushed into an empty FIFO can be popped one cycle later at the earliest.
- State machine (states: IDLE, WAIT, WRITE):
  - IDLE: on REQ=1, capture REQ_RD into rd_q and go to WAIT. Otherwise stay.
  - WAIT: if COUNT>0, pop the head into data_q and go to WRITE. Otherwise stay (stall indefinitely).
  - WRITE: go to IDLE unconditionally.
- Outputs:
  - BUSY = 1 in WAIT and WRITE, registered from the state.
  - INE, INDATA=data_q, IN_WADDR=rd_q and DONE are all valid only in WRITE and are high for exactly one cycle.
  - In all other states INE=0 and DONE=0; INDATA and IN_WADDR hold their last values.
  - If rd_q==0: the byte is still consumed and DONE still pulses, but INE stays 0 (writes to x0 are discarded).
- Latency: with a non-empty FIFO, REQ at edge n means the pop happens at edge n+1 and INE/DONE are high during cycle n+2. The total IN instruction occupies 2 stall cycles.
- Ignored requests: REQ while not in IDLE is ignored; the core guarantees it holds issue while BUSY=1.
- COUNT arithmetic: AW+1 bits; full is COUNT==DEPTH, empty is COUNT==0.

Decomposition:
- Shared package core_pkg:
  - state encoding constants INP_IDLE=2'd0, INP_WAIT=2'd1, INP_WRITE=2'd2;
  - REG_ZERO=5'd0.
- One sub-module, core_byte_fifo:
  - parameterised DEPTH/AW, synchronous active-low reset;
  - ports push/pop/din/dout/count/full/empty.
- core_inport instantiates core_byte_fifo and holds the FSM, rd_q, data_q and the OVERFLOW flag.

Test Plan:
- Basic read:
  - Stimulus: push 0x41; after 2 idle cycles, REQ with REQ_RD=5.
  - Required: BUSY high for 2 cycles; INE=1, INDATA=0x41, IN_WADDR=5 and DONE=1 in the cycle 2 after REQ; COUNT 1→0.
- Stall:
  - Stimulus: REQ with REQ_RD=7 and the FIFO empty; hold for 10 cycles, then push 0x5A.
  - Required: BUSY stays high throughout; INE fires exactly 2 cycles after the push with INDATA=0x5A, IN_WADDR=7.
- Fill and overflow:
  - Stimulus: push 17 bytes 0x00..0x10 back-to-back.
  - Required: RX_READY falls after the 16th byte; COUNT=16; OVERFLOW=1; 16 subsequent REQs return 0x00..0x0F in order; 0x10 is lost.
- Wrap-around and concurrency:
  - Stimulus: repeatedly push one byte per cycle while issuing REQs, for 40 bytes.
  - Required: all 40 bytes are delivered in order across the pointer wrap; COUNT never exceeds DEPTH.
- x0 destination:
  - Stimulus: push 0x33, REQ with REQ_RD=0.
  - Required: DONE=1, INE=0, COUNT 1→0.
- Reset mid-operation:
  - Stimulus: push 3 bytes, REQ, assert RST_N=0 for 1 cycle while in WAIT/WRITE.
  - Required: after reset, COUNT=0, BUSY=0, INE=0, OVERFLOW=0, and no write occurs.
